// File: rtl/register_file.sv
// RV32I-style integer register file: 2**ADDR_WIDTH registers, x0 hard-wired to zero,
// two combinational read ports, one write port. Define REGFILE_WRITE_BYPASS_EN for same-cycle write forwarding.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);
  localparam int NUM_REGS  = 2**ADDR_WIDTH;
  localparam int NUM_PORTS = 2;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] raddr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;
  logic                                 wr_fire;

  assign wr_fire = write_enable && (write_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_fire) regs_d[write_addr] = write_data;
    // x0 is never stored, so the zero read of address 0 is structural
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign raddr = {read_addr2, read_addr1};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    always_comb begin
      rdata[p] = regs_q[raddr[p]];
`ifdef REGFILE_WRITE_BYPASS_EN
      // forward the in-flight write; reset suppresses it since the write will be dropped
      if (wr_fire && !rst && (raddr[p] == write_addr)) rdata[p] = write_data;
`endif
      if (raddr[p] == '0) rdata[p] = '0;
    end
  end

  assign read_data1 = rdata[0];
  assign read_data2 = rdata[1];
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: array model checked every negedge plus literal spot checks.
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1, read_addr2;
  logic [31:0] read_data1, read_data2;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model [32];
  bit          model_ok = 1'b0;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  // register-file semantics at the edge
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_ok = 1'b1;
    end else if (write_enable && write_addr != 5'd0) begin
      model[write_addr] = write_data;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && write_enable && !rst && write_addr == a) return write_data;
    return model[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cyc_rd1", read_data1, exp_rd(read_addr1));
      chk("cyc_rd2", read_data2, exp_rd(read_addr2));
    end
  end

  task automatic set_in(input logic r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
    rst = r; write_enable = we; write_addr = wa; write_data = wd;
    read_addr1 = a1; read_addr2 = a2;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    tick();

    // all addresses read zero after reset
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      read_addr1 = 5'(a);
      read_addr2 = 5'(31 - a);
      #1;
      chk("rst_rd1", read_data1, 32'h0);
      chk("rst_rd2", read_data2, 32'h0);
    end
    @(negedge clk); #1;

    // basic write then read
    set_in(1'b0, 1'b1, 5'd1, 32'h0000_00FF, 5'd0, 5'd0);
    tick();
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0);
    #1;
    chk("x1_rd1", read_data1, 32'h0000_00FF);
    chk("x0_rd2", read_data2, 32'h0);

    // write to x0 discarded
    set_in(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    #1;
    chk("x0_wr_pre", read_data1, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    chk("x0_rd1", read_data1, 32'h0);
    chk("x0_rd2", read_data2, 32'h0);
    read_addr1 = 5'd1; read_addr2 = 5'd5; #1;
    chk("x1_kept", read_data1, 32'h0000_00FF);
    chk("x5_kept", read_data2, 32'h0);

    // read of the register being written in the same cycle
    set_in(1'b0, 1'b1, 5'd2, 32'h0000_00BB, 5'd2, 5'd1);
    #1;
    chk("x2_pre_edge", read_data1, BYP ? 32'h0000_00BB : 32'h0);
    chk("x1_during_wr", read_data2, 32'h0000_00FF);
    tick();
    chk("x2_post_edge", read_data1, 32'h0000_00BB);
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd2);
    #1;
    chk("x2_both_rd1", read_data1, 32'h0000_00BB);
    chk("x2_both_rd2", read_data2, 32'h0000_00BB);

    // reset beats a simultaneous write
    set_in(1'b1, 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd1);
    #1;
    chk("rst_no_bypass", read_data1, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd1);
    #1;
    chk("x3_after_rst", read_data1, 32'h0);
    chk("x1_after_rst", read_data2, 32'h0);
    set_in(1'b0, 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd0);
    tick();
    write_enable = 1'b0;
    #1;
    chk("x3_rewrite", read_data1, 32'h1234_5678);

    // fill all registers with distinct values, check pairs for aliasing
    for (int i = 1; i < 32; i++) begin
      set_in(1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'(32 - i));
      tick();
    end
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      read_addr1 = 5'(i);
      read_addr2 = 5'(32 - i);
      #1;
      chk("fill_rd1", read_data1, 32'h100 + 32'(i));
      chk("fill_rd2", read_data2, 32'h100 + 32'(32 - i));
    end
    @(negedge clk); #1;

    // reset pulse between edges has no effect
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    #2;
    chk("mid_rst_rd1", read_data1, 32'h0000_0105);
    rst = 1'b0;
    tick();
    chk("mid_rst_kept1", read_data1, 32'h0000_0105);
    chk("mid_rst_kept2", read_data2, 32'h0000_011F);

    // write_enable low: data/address wiggle changes nothing
    set_in(1'b0, 1'b0, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd8);
    tick();
    chk("we0_x7", read_data1, 32'h0000_0107);
    chk("we0_x8", read_data2, 32'h0000_0108);

    // random traffic, checked by the per-cycle compare
    for (int n = 0; n < 200; n++) begin
      set_in(($urandom_range(0, 19) == 0), 1'($urandom), 5'($urandom), $urandom,
             5'($urandom), 5'($urandom));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, width of each register and of the data ports.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, address width; register count is 2**ADDR_WIDTH (32).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port write_enable, input, 1 bit, write strobe sampled at the rising clk edge.
REQ-007 The block SHALL have port write_addr, input, ADDR_WIDTH bits, destination register index.
REQ-008 The block SHALL have port write_data, input, DATA_WIDTH bits, value to write.
REQ-009 The block SHALL have port read_addr1, input, ADDR_WIDTH bits, source index for read port 1.
REQ-010 The block SHALL have port read_addr2, input, ADDR_WIDTH bits, source index for read port 2.
REQ-011 The block SHALL have port read_data1, output, DATA_WIDTH bits, contents of register read_addr1.
REQ-012 The block SHALL have port read_data2, output, DATA_WIDTH bits, contents of register read_addr2.

Function
REQ-013 The block SHALL hold 32 registers x0..x31, RV32I integer register file semantics.
REQ-014 Reads SHALL be combinational: read_data1/2 track read_addr1/2 and register contents within the same cycle, zero clock latency.
REQ-015 A read of address 0 on either port SHALL return 0 regardless of any write.
REQ-016 When write_enable=1 at a rising clk edge with write_addr!=0, register[write_addr] SHALL take write_data at that edge; visible on read ports immediately after the edge.
REQ-017 A write with write_addr=0 SHALL be discarded; x0 is never stored.
REQ-018 When write_enable=0, no register SHALL change.
REQ-019 Both read ports SHALL be independent; both may address the same register simultaneously and both return the same value.
REQ-020 A read of the register being written in the same cycle SHALL return the old value until the edge (write-first bypass only per REQ-026).
REQ-021 Exactly one register SHALL change per enabled write; no other register is disturbed.

Reset
REQ-022 When rst=1 at a rising clk edge, all registers SHALL clear to 0; both read outputs then read 0 for any address.
REQ-023 rst SHALL take priority over a simultaneous write; the write is discarded.
REQ-024 Reset asserted between edges SHALL have no effect until the next rising edge (synchronous).

Configuration
REQ-025 Macro REGFILE_WRITE_BYPASS_EN SHALL select same-cycle write forwarding.
REQ-026 With REGFILE_WRITE_BYPASS_EN defined: if write_enable=1, rst=0, write_addr!=0 and read_addrN==write_addr, read_dataN SHALL equal write_data combinationally before the edge; address 0 still reads 0.
REQ-027 Without REGFILE_WRITE_BYPASS_EN: read ports SHALL return only stored contents (REQ-020).

Verification
REQ-028 Reset then read all 32 addresses on both ports -> all return 0.
REQ-029 Write x1=0x000000FF (write_enable=1) at edge, then write_enable=0, read_addr1=1 -> read_data1=0x000000FF; read_addr2=0 -> read_data2=0.
REQ-030 Write x0=0xFFFFFFFF -> read of address 0 on both ports returns 0; x1..x31 unchanged.
REQ-031 Set write_enable=1, write_addr=2, write_data=0x000000BB, read_addr1=2 before edge -> read_data1=0 before edge (0xBB if bypass enabled), 0xBB after edge.
REQ-032 Assert rst and write x3=0x12345678 at the same edge -> x3 reads 0; a subsequent write with rst=0 stores 0x12345678.
REQ-033 Fill x1..x31 with distinct values (e.g. 0x100+index), read pairs across both ports -> each returns its own value, with no aliasing.
